// File: rtl/oscu_pkg.sv
// Shared types and constants for the sweep arbiter and its address counter.
package oscu_pkg;

  localparam int OSCU_ADDR_BITS = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } oscu_state_e;

endpackage

// File: rtl/oscu_addr_counter.sv
// Loadable wrapping up-counter with a terminal-value match flag.
module oscu_addr_counter
  import oscu_pkg::*;
#(
  parameter int ADDR_BITS = OSCU_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_value,
  input  logic                 enable,
  input  logic [ADDR_BITS-1:0] terminal_value,
  output logic [ADDR_BITS-1:0] count,
  output logic                 match
);

  logic [ADDR_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign match = (count_q == terminal_value);

endmodule

// File: rtl/oscu_sweep_arbiter.sv
// Round-robin arbiter granting one requester at a time an address sweep start..end.
// Optional macro OSCU_SWEEP_ABORT_EN enables the abort input in LOAD/RUN.
module oscu_sweep_arbiter
  import oscu_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = OSCU_ADDR_BITS
) (
  input  logic                           clk2,
  input  logic                           Reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   start_addr,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   end_addr,
  input  logic                           step,
  input  logic                           abort,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [ADDR_BITS-1:0]           CurrentAdd
);

  localparam int IDX_W = $clog2(NUM_REQ);

  oscu_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic [IDX_W-1:0]     owner_q, owner_d, last_q, last_d, win_idx;
  logic [ADDR_BITS-1:0] end_q, end_d, sel_start, sel_end;
  logic                 cnt_load, cnt_en, cnt_match, abort_hit;

  // First requester found scanning upward from the one after the last winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   last);
    logic [NUM_REQ-1:0] rot;
    int                 idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      rot = r >> idx;
      if (rot[0]) rr_pick = IDX_W'(idx);
    end
  endfunction

  assign win_idx   = rr_pick(req, last_q);
  assign sel_start = ADDR_BITS'(start_addr >> (int'(owner_q) * ADDR_BITS));
  assign sel_end   = ADDR_BITS'(end_addr >> (int'(owner_q) * ADDR_BITS));

`ifdef OSCU_SWEEP_ABORT_EN
  assign abort_hit = abort & ((state_q == ST_LOAD) | (state_q == ST_RUN));
`else
  assign abort_hit = abort & 1'b0;
`endif

  always_ff @(posedge clk2 or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Terminal address is pure data, latched in LOAD and only read in RUN.
  always_ff @(posedge clk2) begin
    end_q <= end_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_LOAD;
      ST_LOAD: state_d = abort_hit ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort_hit)              state_d = ST_IDLE;
        else if (step && cnt_match) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    done_d   = '0;
    owner_d  = owner_q;
    last_d   = last_q;
    end_d    = end_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
        end
      end
      ST_LOAD: begin
        if (abort_hit) begin
          grant_d = '0;
          last_d  = owner_q;
        end else begin
          cnt_load = 1'b1;
          end_d    = sel_end;
        end
      end
      ST_RUN: begin
        if (abort_hit) begin
          grant_d = '0;
          last_d  = owner_q;
        end else if (step && cnt_match) begin
          done_d = NUM_REQ'(1) << owner_q;
        end else if (step) begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        last_d  = owner_q;
      end
      default: grant_d = '0;
    endcase
  end

  oscu_addr_counter #(
    .ADDR_BITS(ADDR_BITS)
  ) u_counter (
    .clk           (clk2),
    .rst           (Reset),
    .load          (cnt_load),
    .load_value    (sel_start),
    .enable        (cnt_en),
    .terminal_value(end_q),
    .count         (CurrentAdd),
    .match         (cnt_match)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
